// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the synchronous FIFO controller.
package sync_fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_RAM_DEEPTH = 1024;

  // Ceiling log2. Values of 0 and 1 return 0.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (value > (1 << i)) r = i + 1;
    end
    return r;
  endfunction

  // Pointers carry one extra MSB so that full and empty can be told apart.
  function automatic int ptr_width(input int depth);
    return clogb2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer, occupancy and flag controller driving a 1-cycle-latency dual-port RAM.
// Accept decisions use only registered flags; all flags come from next_count.
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int RAM_DEEPTH      = DEFAULT_RAM_DEEPTH,
  parameter int ALMOST_FULL_TH  = 1020,
  parameter int ALMOST_EMPTY_TH = 4,
  localparam int ADDR_WIDTH     = clogb2(RAM_DEEPTH),
  localparam int PTR_WIDTH      = ptr_width(RAM_DEEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [ADDR_WIDTH:0]   data_count_o,
  output logic                  overflow_o,
  output logic                  underflow_o,
  output logic                  ram_rst_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] count;
  logic [PTR_WIDTH-1:0] next_count;
  logic                 ram_rst;
  logic                 wr_acc;
  logic                 rd_acc;

  // RAM reset asserts with rst_n_i and releases one edge after it rises.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ram_rst <= 1'b1;
    else          ram_rst <= 1'b0;
  end

  assign wr_acc = wr_en_i & ~full_o & ~ram_rst;
  assign rd_acc = rd_en_i & ~empty_o & ~ram_rst;

  assign ram_rst_o     = ram_rst;
  assign ram_wr_en_o   = wr_acc;
  assign ram_wr_addr_o = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data_o = wr_data_i;
  assign ram_rd_en_o   = rd_acc;
  assign ram_rd_addr_o = rd_ptr[ADDR_WIDTH-1:0];
  assign rd_data_o     = ram_rd_data_i;
  assign data_count_o  = count;

  always_comb begin
    next_count = count;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = count + PTR_WIDTH'(1);
      2'b01:   next_count = count - PTR_WIDTH'(1);
      default: next_count = count;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      full_o         <= 1'b0;
      empty_o        <= 1'b1;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
      rd_valid_o     <= 1'b0;
      overflow_o     <= 1'b0;
      underflow_o    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      count          <= next_count;
      full_o         <= (next_count == PTR_WIDTH'(RAM_DEEPTH));
      empty_o        <= (next_count == '0);
      almost_full_o  <= (next_count >= PTR_WIDTH'(ALMOST_FULL_TH));
      almost_empty_o <= (next_count <= PTR_WIDTH'(ALMOST_EMPTY_TH));
      rd_valid_o     <= rd_acc;
      // Rejections while the RAM is still held in reset are not reported.
      overflow_o     <= wr_en_i & ~wr_acc & ~ram_rst;
      underflow_o    <= rd_en_i & ~rd_acc & ~ram_rst;
    end
  end

  a_empty_ptrs : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (count == '0) == (wr_ptr == rd_ptr));

  a_full_ptrs : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (count == PTR_WIDTH'(RAM_DEEPTH)) ==
    ((wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0])));

  a_count_ptrs : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    count == PTR_WIDTH'(wr_ptr - rd_ptr));

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 8;
  localparam int AF_TH = 6;
  localparam int AE_TH = 1;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       wr_en_i = 1'b0;
  logic [7:0] wr_data_i = 8'h00;
  logic       rd_en_i = 1'b0;
  logic [7:0] rd_data_o;
  logic       rd_valid_o, full_o, empty_o, almost_full_o, almost_empty_o;
  logic [3:0] data_count_o;
  logic       overflow_o, underflow_o, ram_rst_o;
  logic       ram_wr_en_o, ram_rd_en_o;
  logic [2:0] ram_wr_addr_o, ram_rd_addr_o;
  logic [7:0] ram_wr_data_o;
  logic [7:0] ram_rd_data_i = 8'h00;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8), .RAM_DEEPTH(DEPTH),
    .ALMOST_FULL_TH(AF_TH), .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .wr_en_i(wr_en_i), .wr_data_i(wr_data_i), .rd_en_i(rd_en_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .full_o(full_o), .empty_o(empty_o),
    .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .data_count_o(data_count_o),
    .overflow_o(overflow_o), .underflow_o(underflow_o),
    .ram_rst_o(ram_rst_o),
    .ram_wr_en_o(ram_wr_en_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_en_o(ram_rd_en_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Companion RAM: registered read, no reset of the array.
  logic [7:0] mem [DEPTH];
  always @(posedge clk_i) begin
    if (ram_wr_en_o) mem[ram_wr_addr_o] <= ram_wr_data_o;
    if (ram_rd_en_o) ram_rd_data_i <= mem[ram_rd_addr_o];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, popped words queued for the monitor.
  logic [7:0] q[$];
  logic [7:0] exp_q[$];
  bit m_ram_rst = 1'b1;
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  int wr_total = 0;
  int rd_total = 0;

  always @(negedge rst_n_i) begin
    q.delete();
    exp_q.delete();
    m_ram_rst = 1'b1;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    wr_total = 0;
    rd_total = 0;
  end

  always @(posedge clk_i) begin
    if (rst_n_i) begin
      if (m_ram_rst) begin
        m_ram_rst = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end else begin
        bit wa, ra;
        wa = wr_en_i && (q.size() < DEPTH);
        ra = rd_en_i && (q.size() > 0);
        m_ovf = wr_en_i && !wa;
        m_udf = rd_en_i && !ra;
        if (ra) begin
          exp_q.push_back(q.pop_front());
          rd_total++;
        end
        if (wa) begin
          q.push_back(wr_data_i);
          wr_total++;
        end
      end
    end
  end

  // Monitor: every rd_valid_o must match the oldest outstanding expected word.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (rd_valid_o) begin
        if (exp_q.size() == 0) chk("rd_valid_spurious", 1, 0);
        else chk("rd_data", {24'h0, rd_data_o}, {24'h0, exp_q.pop_front()});
      end else if (exp_q.size() != 0) begin
        chk("rd_valid_missing", 0, 1);
        exp_q.delete();
      end
    end
  end

  task automatic check_state();
    chk("data_count", data_count_o, q.size());
    chk("full", full_o, q.size() == DEPTH);
    chk("empty", empty_o, q.size() == 0);
    chk("almost_full", almost_full_o, q.size() >= AF_TH);
    chk("almost_empty", almost_empty_o, q.size() <= AE_TH);
    chk("overflow", overflow_o, m_ovf);
    chk("underflow", underflow_o, m_udf);
    chk("ram_rst", ram_rst_o, m_ram_rst);
  endtask

  task automatic cycle(input bit w, input bit r, input logic [7:0] d);
    bit wa, ra;
    @(negedge clk_i);
    check_state();
    wr_en_i = w;
    rd_en_i = r;
    wr_data_i = d;
    #1;
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    chk("ram_wr_en", ram_wr_en_o, wa);
    chk("ram_rd_en", ram_rd_en_o, ra);
    if (wa) begin
      chk("ram_wr_addr", ram_wr_addr_o, wr_total % DEPTH);
      chk("ram_wr_data", ram_wr_data_o, d);
    end
    if (ra) chk("ram_rd_addr", ram_rd_addr_o, rd_total % DEPTH);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00);
  endtask

  task automatic release_reset();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    chk("ram_rst_held_after_release", ram_rst_o, 1);
  endtask

  initial begin
    int pw, pr;
    repeat (3) @(negedge clk_i);
    chk("reset_count", data_count_o, 0);
    chk("reset_empty", empty_o, 1);
    chk("reset_almost_empty", almost_empty_o, 1);
    chk("reset_ram_rst", ram_rst_o, 1);
    release_reset();

    // 1: three pushes then three pops
    cycle(1, 0, 8'h11); cycle(1, 0, 8'h22); cycle(1, 0, 8'h33);
    cycle(0, 1, 8'h00); cycle(0, 1, 8'h00); cycle(0, 1, 8'h00);
    idle(); idle();
    chk("t1_empty", empty_o, 1);
    chk("t1_count", data_count_o, 0);

    // 2: fill to full, then one rejected push
    for (int i = 0; i < 8; i++) cycle(1, 0, 8'hA0 + 8'(i));
    cycle(1, 0, 8'hEE);
    chk("t2_full", full_o, 1);
    chk("t2_count8", data_count_o, 8);
    idle();
    chk("t2_overflow_pulse", overflow_o, 1);
    chk("t2_count_stays", data_count_o, 8);

    // 3: push and pop together while full
    cycle(1, 1, 8'hBB);
    idle();
    chk("t3_count7", data_count_o, 7);
    chk("t3_not_full", full_o, 0);
    chk("t3_overflow", overflow_o, 1);
    for (int i = 0; i < 7; i++) cycle(0, 1, 8'h00);
    idle();
    chk("t3_drained", empty_o, 1);

    // 4: push and pop together while empty
    cycle(1, 1, 8'h5A);
    idle();
    chk("t4_underflow", underflow_o, 1);
    chk("t4_no_valid", rd_valid_o, 0);
    chk("t4_count1", data_count_o, 1);
    cycle(0, 1, 8'h00);
    idle();

    // 5: steady push+pop at occupancy 4
    for (int i = 0; i < 4; i++) cycle(1, 0, 8'hC0 + 8'(i));
    for (int i = 0; i < 20; i++) cycle(1, 1, 8'(i * 7 + 3));
    idle();
    chk("t5_count4", data_count_o, 4);
    for (int i = 0; i < 4; i++) cycle(0, 1, 8'h00);
    idle();

    // 6: asynchronous reset at occupancy 5
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'hD0 + 8'(i));
    @(negedge clk_i);
    check_state();
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("t6_async_count", data_count_o, 0);
    chk("t6_async_empty", empty_o, 1);
    chk("t6_async_full", full_o, 0);
    chk("t6_async_af", almost_full_o, 0);
    chk("t6_async_ae", almost_empty_o, 1);
    chk("t6_async_valid", rd_valid_o, 0);
    chk("t6_async_ram_rst", ram_rst_o, 1);
    repeat (2) @(negedge clk_i);
    release_reset();
    cycle(1, 0, 8'h77);
    cycle(0, 1, 8'h00);
    idle(); idle();

    // Random traffic with shifting push/pop bias
    for (int blk = 0; blk < 10; blk++) begin
      pw = 20 + 30 * $urandom_range(2);
      pr = 20 + 30 * $urandom_range(2);
      for (int i = 0; i < 40; i++)
        cycle($urandom_range(99) < pw, $urandom_range(99) < pr, 8'($urandom));
    end
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Pointer/flag controller for the synchronous FIFO. It sits directly upstream of simple_double_port_ram and drives that RAM's write and read ports from a single clock domain. It converts user push/pop requests into RAM write enables and addresses, keeps the occupancy count and status flags, and qualifies the RAM's registered read data with a valid strobe.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM instance.
RAM_DEEPTH, 1024, FIFO depth in words; power of two, minimum 4.
ALMOST_FULL_TH, 1020, almost_full_o asserts when count >= this value.
ALMOST_EMPTY_TH, 4, almost_empty_o asserts when count <= this value.
(Local) ADDR_WIDTH = clogb2(RAM_DEEPTH). Pointers are ADDR_WIDTH+1 bits.

Ports:
clk_i  in  1  single clock; drives the controller and both RAM clocks.
rst_n_i  in  1  asynchronous, active-low reset.
wr_en_i  in  1  push request.
wr_data_i  in  DATA_WIDTH  push data.
rd_en_i  in  1  pop request.
rd_data_o  out  DATA_WIDTH  popped word; equals ram_rd_data_i; meaningful only while rd_valid_o=1.
rd_valid_o  out  1  registered; high the cycle after an accepted pop.
full_o  out  1  registered; count == RAM_DEEPTH.
empty_o  out  1  registered; count == 0.
almost_full_o  out  1  registered; count >= ALMOST_FULL_TH.
almost_empty_o  out  1  registered; count <= ALMOST_EMPTY_TH.
data_count_o  out  ADDR_WIDTH+1  registered occupancy, 0..RAM_DEEPTH.
overflow_o  out  1  one-cycle pulse: push rejected in the previous cycle.
underflow_o  out  1  one-cycle pulse: pop rejected in the previous cycle.
ram_rst_o  out  1  active-high reset to the RAM's wr_rst_i and rd_rst_i.
ram_wr_en_o  out  1  to RAM wr_en_i.
ram_wr_addr_o  out  ADDR_WIDTH  to RAM wr_addr_i.
ram_wr_data_o  out  DATA_WIDTH  to RAM wr_data_i.
ram_rd_en_o  out  1  to RAM rd_en_i.
ram_rd_addr_o  out  ADDR_WIDTH  to RAM rd_addr_i.
ram_rd_data_i  in  DATA_WIDTH  from RAM rd_data_o (1-cycle registered read).

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - wr_ptr=rd_ptr=0, count=0.
  - empty_o=1, almost_empty_o=1; full_o, almost_full_o, rd_valid_o, overflow_o, underflow_o=0.
  - ram_rst_o=1, asserted asynchronously. It deasserts on the first clk_i edge after rst_n_i rises (one register stage).
- Accept rules use the registered flags only:
  - wr_acc = wr_en_i & ~full_o.
  - rd_acc = rd_en_i & ~empty_o.
  - While ram_rst_o=1, wr_acc and rd_acc are forced to 0.
- RAM drive is combinational:
  - ram_wr_en_o = wr_acc; ram_wr_addr_o = wr_ptr[ADDR_WIDTH-1:0]; ram_wr_data_o = wr_data_i.
  - ram_rd_en_o = rd_acc; ram_rd_addr_o = rd_ptr[ADDR_WIDTH-1:0].
- Pointer update on clock edge:
  - wr_acc increments wr_ptr; rd_acc increments rd_ptr.
  - Pointers wrap naturally through the extra MSB.
- Read latency: one cycle. If rd_acc occurs in cycle t, then in t+1 rd_valid_o=1 and rd_data_o holds the word at the old rd_ptr. Back-to-back pops give one word per cycle.
- Count update:
  - next_count = count + wr_acc - rd_acc.
  - Simultaneous wr_acc and rd_acc leave count unchanged.
  - All four flags are computed from next_count and registered, so they are valid in the same cycle as data_count_o.
- Full with simultaneous push and pop: pop accepted, push rejected, overflow pulses. The next cycle has count = RAM_DEEPTH-1 and full_o=0.
- Empty with simultaneous push and pop: push accepted, pop rejected, underflow pulses, rd_valid_o=0. The next cycle has count=1 and empty_o=0. There is no fall-through.
- Address collision: a read from the address being written in the same cycle never occurs, because rd_acc needs count >= 1, which forces rd_ptr != wr_ptr.
- Pointer equality invariants:
  - Full when the pointer MSBs differ and the lower bits are equal.
  - Empty when the pointers are identical.
  - Assertions must check that these agree with count.
- Reset mid-operation: all state returns to reset values immediately. Contents are discarded logically; the RAM array is not cleared.

Decomposition:
- Shared package sync_fifo_pkg holds:
  - the clogb2 function;
  - default DATA_WIDTH and RAM_DEEPTH constants;
  - a pointer-width helper.
- No sub-module inside the controller. The existing simple_double_port_ram is the natural companion instance, wired by a thin sync_fifo top that ties wr_clk_i and rd_clk_i to clk_i.

Test Plan:
All scenarios use RAM_DEEPTH=8, DATA_WIDTH=8, ALMOST_FULL_TH=6, ALMOST_EMPTY_TH=1, with the companion RAM instantiated.
1. Reset, then push 0x11,0x22,0x33 and pop three times -> rd_valid_o high on the three cycles after each pop with data 0x11,0x22,0x33; count ends at 0; empty_o=1.
2. Push 8 words 0xA0..0xA7 -> full_o=1 and count=8 after the 8th edge; almost_full_o from count 6; a 9th push gives overflow_o pulse and count stays 8.
3. From full, assert push and pop together -> pop returns 0xA0; push rejected with overflow pulse; count=7; full_o=0.
4. From empty, assert push 0x5A and pop together -> underflow pulse, rd_valid_o=0, count=1; pop next cycle returns 0x5A.
5. Do 20 cycles of continuous simultaneous push/pop at count=4 (pointers wrap twice) -> count constant at 4, output order matches input order, no flag toggles.
6. Drop rst_n_i mid-stream at count=5 -> all outputs take reset values asynchronously; ram_rst_o high until the first edge after release; the next push/pop round-trip works from address 0.
